// File: rtl/ext_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ext_pkg
//  Description : Shared immediate-extension mode encodings, used by the
//                instruction decoder and the immediate extension pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
package ext_pkg;

    // Extension modes carried on the 2-bit op field
    typedef enum logic [1:0] {
        EXT_ZERO   = 2'd0,  // {zeros, imm}
        EXT_SIGN   = 2'd1,  // {sign, imm}
        EXT_UPPER  = 2'd2,  // {imm, zeros}
        EXT_BRANCH = 2'd3   // {sign, imm, 2'b00}
    } ext_op_e;

    localparam int c_FIFO_DEPTH = 2;

endpackage : ext_pkg
`default_nettype wire

// File: rtl/imm_ext_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_pipe_if
//  Description : Valid/ready bus around the immediate extension pipe. The
//                master side is the surrounding pipeline (upstream producer
//                and downstream consumer); the slave side is the block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, in_imm, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  flush, in_valid, in_imm, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface : imm_ext_pipe_if
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_core
//  Description : Purely combinational immediate extension mux. Every mode
//                produces a fully defined result.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32   // must be at least IN_W + 2
) (
    input  wire logic [IN_W-1:0]  i_imm,
    input  wire logic [1:0]       i_op,
    output logic      [OUT_W-1:0] o_result
);

    localparam int c_PAD = OUT_W - IN_W;

    logic             w_sign;
    logic [OUT_W-1:0] w_zero_ext;
    logic [OUT_W-1:0] w_sign_ext;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_branch;

    assign w_sign     = i_imm[IN_W-1];
    assign w_zero_ext = {{c_PAD{1'b0}}, i_imm};
    assign w_sign_ext = {{c_PAD{w_sign}}, i_imm};
    assign w_upper    = {i_imm, {c_PAD{1'b0}}};

    // Branch offset needs two spare bits for the shift; with exactly two
    // there is no room left for sign replication.
    generate
        if (c_PAD == 2) begin : g_branch_exact
            assign w_branch = {i_imm, 2'b00};
        end else begin : g_branch_pad
            assign w_branch = {{(c_PAD-2){w_sign}}, i_imm, 2'b00};
        end
    endgenerate

    // Select the extension for the requested mode
    always_comb begin
        o_result = w_zero_ext;
        case (ext_op_e'(i_op))
            EXT_ZERO:   o_result = w_zero_ext;
            EXT_SIGN:   o_result = w_sign_ext;
            EXT_UPPER:  o_result = w_upper;
            EXT_BRANCH: o_result = w_branch;
            default:    o_result = w_zero_ext;
        endcase
    end

endmodule : imm_ext_core
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_pipe
//  Description : Immediate extension stage with a 2-entry skid buffer.
//                The result is computed on input transfer and stored, so
//                out_data always comes from registers. in_ready depends on
//                registered occupancy only.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 32
) (
    input  wire logic       clk,
    input  wire logic       reset,
    imm_ext_pipe_if.slave   bus
);

    logic [OUT_W-1:0] w_ext;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;

    logic [OUT_W-1:0] r_data [c_FIFO_DEPTH];
    logic [TAG_W-1:0] r_tag  [c_FIFO_DEPTH];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_imm    (bus.in_imm),
        .i_op     (bus.in_op),
        .o_result (w_ext)
    );

    // A full buffer refuses pushes even when a pop happens the same cycle,
    // which keeps out_ready off the in_ready path.
    assign w_in_ready  = (r_count < 2'd2);
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_data[r_rptr];
    assign bus.out_tag   = r_tag[r_rptr];

    // Occupancy and 1-bit wrapping pointers; flush empties the buffer
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the idle output reads zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_FIFO_DEPTH; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else if (w_push && !bus.flush) begin
            r_data[r_wptr] <= w_ext;
            r_tag[r_wptr]  <= bus.in_tag;
        end
    end

endmodule : imm_ext_pipe
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_ext_pipe
//  Description : Directed self-checking bench for imm_ext_pipe, including a
//                narrow IN_W=12 / OUT_W=16 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_ext_pipe;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    imm_ext_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(32)) bus ();
    imm_ext_pipe_if #(.IN_W(12), .OUT_W(16), .TAG_W(8))  bus12 ();

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    imm_ext_pipe #(.IN_W(12), .OUT_W(16), .TAG_W(8)) u_dut12 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_op     = 2'd0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        bus12.flush     = 1'b0;
        bus12.in_valid  = 1'b0;
        bus12.in_imm    = '0;
        bus12.in_op     = 2'd0;
        bus12.in_tag    = '0;
        bus12.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 00000000", bus.out_data); else n_pass++;
        n_total++; if (bus.out_tag !== 32'h0) $display("FAIL reset_out_tag: got %h want 00000000", bus.out_tag); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_modes();
        logic [31:0] exp_tbl [4];
        exp_tbl[0] = 32'h00008001;
        exp_tbl[1] = 32'hFFFF8001;
        exp_tbl[2] = 32'h80010000;
        exp_tbl[3] = 32'hFFFE0004;
        bus.out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = 16'h8001;
            bus.in_op    = 2'(m);
            bus.in_tag   = 32'h100 + 32'(m);
            tick();
            bus.in_valid = 1'b0;
            n_total++; if (bus.out_valid !== 1'b1) $display("FAIL mode%0d_valid: got %b want 1", m, bus.out_valid); else n_pass++;
            n_total++; if (bus.out_data !== exp_tbl[m]) $display("FAIL mode%0d_data: got %h want %h", m, bus.out_data, exp_tbl[m]); else n_pass++;
            n_total++; if (bus.out_tag !== 32'h100 + 32'(m)) $display("FAIL mode%0d_tag: got %h want %h", m, bus.out_tag, 32'h100 + 32'(m)); else n_pass++;
            tick();
            n_total++; if (bus.out_valid !== 1'b0) $display("FAIL mode%0d_drain: got %b want 0", m, bus.out_valid); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_op     = 2'd0;
        for (int t = 1; t <= 2; t++) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = 16'(t);
            bus.in_tag   = 32'(t);
            tick();
        end
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_full_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        bus.in_imm = 16'd3;
        bus.in_tag = 32'd3;
        tick();
        bus.in_valid = 1'b0;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_refused_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_tag !== 32'd1) $display("FAIL bp_hold_tag: got %h want 00000001", bus.out_tag); else n_pass++;
        n_total++; if (bus.out_data !== 32'd1) $display("FAIL bp_hold_data: got %h want 00000001", bus.out_data); else n_pass++;
        bus.out_ready = 1'b1;
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 32'd1) $display("FAIL bp_first: got v=%b tag=%h want v=1 tag=00000001", bus.out_valid, bus.out_tag); else n_pass++;
        tick();
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 32'd2) $display("FAIL bp_second: got v=%b tag=%h want v=1 tag=00000002", bus.out_valid, bus.out_tag); else n_pass++;
        n_total++; if (bus.out_data !== 32'd2) $display("FAIL bp_second_data: got %h want 00000002", bus.out_data); else n_pass++;
        tick();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_no_third: got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        bus.in_op     = 2'd1;
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = 16'(i * 701);
            bus.in_tag   = 32'(i);
            n_total++; if (bus.in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b want 1", i, bus.in_ready); else n_pass++;
            tick();
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_tag !== 32'(i) ||
                bus.out_data !== {{16{bus.in_imm[15]}}, bus.in_imm})
                $display("FAIL stream_out[%0d]: got v=%b tag=%h data=%h want v=1 tag=%h data=%h",
                         i, bus.out_valid, bus.out_tag, bus.out_data, 32'(i), {{16{bus.in_imm[15]}}, bus.in_imm});
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        tick();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_op     = 2'd0;
        bus.in_valid  = 1'b1;
        bus.in_tag    = 32'hA;
        tick();
        bus.in_tag    = 32'hB;
        tick();
        bus.in_tag    = 32'hC;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_stays_empty[%0d]: got %b want 0", k, bus.out_valid); else n_pass++;
        end
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'h0042;
        bus.in_tag   = 32'hD;
        tick();
        bus.in_valid = 1'b0;
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 32'hD) $display("FAIL flush_recover: got v=%b tag=%h want v=1 tag=0000000d", bus.out_valid, bus.out_tag); else n_pass++;
        tick();
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        bus.in_op     = 2'd2;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'h1234;
        bus.in_tag    = 32'h55;
        tick();
        bus.in_tag    = 32'h66;
        tick();
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_mid_full: got %b want 0", bus.in_ready); else n_pass++;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_data !== 32'h0) $display("FAIL rst_mid_out_data: got %h want 00000000", bus.out_data); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        tick();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_no_entry: got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_param_variant();
        logic [1:0]  ops  [3];
        logic [15:0] exps [3];
        ops[0] = 2'd3; exps[0] = 16'hE000;
        ops[1] = 2'd1; exps[1] = 16'hF800;
        ops[2] = 2'd2; exps[2] = 16'h8000;
        bus12.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            bus12.in_valid = 1'b1;
            bus12.in_imm   = 12'h800;
            bus12.in_op    = ops[j];
            bus12.in_tag   = 8'(j + 7);
            tick();
            bus12.in_valid = 1'b0;
            n_total++;
            if (bus12.out_valid !== 1'b1 || bus12.out_data !== exps[j] || bus12.out_tag !== 8'(j + 7))
                $display("FAIL narrow_op%0d: got v=%b data=%h tag=%h want v=1 data=%h tag=%h",
                         ops[j], bus12.out_valid, bus12.out_data, bus12.out_tag, exps[j], 8'(j + 7));
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b1;
        test_reset();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_param_variant();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_imm_ext_pipe
`default_nettype wire
